// File: rtl/vga_rect_fill.sv
// Rectangle fill engine driving the frame-buffer write port: latches a command,
// clips it to the visible area and streams one pixel per cycle in row-major order.
module vga_rect_fill #(
  parameter int          H_ACTIVE  = 640,
  parameter int          V_ACTIVE  = 480,
  parameter int          ADDR_W    = 19,
  parameter int unsigned ADDR_BASE = 0
) (
  input  logic              iclk,
  input  logic              iRST_n,
  input  logic              icmd_valid,
  output logic              ocmd_ready,
  input  logic              icmd_clear,
  input  logic [9:0]        ix,
  input  logic [8:0]        iy,
  input  logic [9:0]        iw,
  input  logic [8:0]        ih,
  input  logic [7:0]        icolor,
  input  logic              ihold,
  output logic              owren,
  output logic [7:0]        odata,
  output logic [ADDR_W-1:0] oaddr,
  output logic              obusy,
  output logic              odone
);

  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

  localparam logic [10:0]       H_LIM  = 11'(H_ACTIVE);
  localparam logic [10:0]       V_LIM  = 11'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_ACTIVE);
  localparam logic [ADDR_W-1:0] A_BASE = ADDR_W'(ADDR_BASE);

  function automatic logic [10:0] clip_end(input logic [10:0] sum, input logic [10:0] lim);
    return (sum > lim) ? lim : sum;
  endfunction

  state_t state, state_nxt;

  logic [7:0]        color_q;
  logic [9:0]        x0_q;
  logic [8:0]        y0_q;
  logic [9:0]        w_q;
  logic [8:0]        h_q;
  logic [10:0]       x_end_q;
  logic [10:0]       y_end_q;
  logic [9:0]        cx;
  logic [8:0]        cy;
  logic [ADDR_W-1:0] row_base;

  logic              wren_p1;
  logic [7:0]        data_p1;
  logic [ADDR_W-1:0] addr_p1;

  logic [10:0]       x_end_c;
  logic [10:0]       y_end_c;
  logic              empty_c;
  logic [ADDR_W-1:0] row_base_init;
  logic              last_col;
  logic              last_row;
  logic              last_px;
  logic [9:0]        cx_nxt;
  logic [8:0]        cy_nxt;
  logic [ADDR_W-1:0] rb_nxt;

  // Setup arithmetic: widened sums cannot wrap, so clipping is a plain min.
  always_comb begin
    x_end_c       = clip_end({1'b0, x0_q} + {1'b0, w_q}, H_LIM);
    y_end_c       = clip_end({2'b0, y0_q} + {2'b0, h_q}, V_LIM);
    empty_c       = (w_q == '0) || (h_q == '0) ||
                    ({1'b0, x0_q} >= H_LIM) || ({2'b0, y0_q} >= V_LIM);
    row_base_init = ADDR_W'(y0_q) * H_STEP;
  end

  // Raster stepping: line wrap adds one line stride instead of multiplying per pixel.
  always_comb begin
    last_col = ({1'b0, cx} == x_end_q - 11'd1);
    last_row = ({2'b0, cy} == y_end_q - 11'd1);
    last_px  = last_col && last_row;
    if (last_col) begin
      cx_nxt = x0_q;
      cy_nxt = cy + 9'd1;
      rb_nxt = row_base + H_STEP;
    end else begin
      cx_nxt = cx + 10'd1;
      cy_nxt = cy;
      rb_nxt = row_base;
    end
  end

  always_ff @(posedge iclk or negedge iRST_n) begin
    if (!iRST_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ocmd_ready = 1'b0;
    obusy      = 1'b0;
    odone      = 1'b0;
    case (state)
      IDLE: begin
        ocmd_ready = 1'b1;
        if (icmd_valid) state_nxt = SETUP;
      end
      SETUP: begin
        obusy     = 1'b1;
        state_nxt = empty_c ? DONE : FILL;
      end
      FILL: begin
        obusy = 1'b1;
        if (!ihold && last_px) state_nxt = DONE;
      end
      DONE: begin
        obusy     = 1'b1;
        odone     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: the pixel currently presented on the write port; SETUP preloads the
  // first one so the stream starts two cycles after accept.
  always_ff @(posedge iclk or negedge iRST_n) begin
    if (!iRST_n) begin
      color_q  <= '0;
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      x_end_q  <= '0;
      y_end_q  <= '0;
      cx       <= '0;
      cy       <= '0;
      row_base <= '0;
      wren_p1  <= 1'b0;
      data_p1  <= '0;
      addr_p1  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (icmd_valid) begin
            color_q <= icolor;
            if (icmd_clear) begin
              x0_q <= '0;
              y0_q <= '0;
              w_q  <= 10'(H_ACTIVE);
              h_q  <= 9'(V_ACTIVE);
            end else begin
              x0_q <= ix;
              y0_q <= iy;
              w_q  <= iw;
              h_q  <= ih;
            end
          end
        end
        SETUP: begin
          x_end_q <= x_end_c;
          y_end_q <= y_end_c;
          if (!empty_c) begin
            cx       <= x0_q;
            cy       <= y0_q;
            row_base <= row_base_init;
            wren_p1  <= 1'b1;
            data_p1  <= color_q;
            addr_p1  <= A_BASE + row_base_init + ADDR_W'(x0_q);
          end
        end
        FILL: begin
          if (!ihold) begin
            if (last_px) begin
              wren_p1 <= 1'b0;
            end else begin
              cx       <= cx_nxt;
              cy       <= cy_nxt;
              row_base <= rb_nxt;
              addr_p1  <= A_BASE + rb_nxt + ADDR_W'(cx_nxt);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // A stalled pixel stays presented with the enable dropped, so it is written
  // exactly once when the hold releases.
  assign owren = wren_p1 & ~ihold;
  assign odata = data_p1;
  assign oaddr = addr_p1;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Randomised scoreboard bench for vga_rect_fill: a rectangle model fills an
// expected-write queue at accept time and a monitor drains it as writes appear.
module tb_vga_rect_fill;
  localparam int H = 640;
  localparam int V = 480;

  logic        iclk;
  logic        iRST_n;
  logic        icmd_valid;
  logic        ocmd_ready;
  logic        icmd_clear;
  logic [9:0]  ix;
  logic [8:0]  iy;
  logic [9:0]  iw;
  logic [8:0]  ih;
  logic [7:0]  icolor;
  logic        ihold;
  logic        owren;
  logic [7:0]  odata;
  logic [18:0] oaddr;
  logic        obusy;
  logic        odone;

  vga_rect_fill dut (
    .iclk(iclk), .iRST_n(iRST_n), .icmd_valid(icmd_valid), .ocmd_ready(ocmd_ready),
    .icmd_clear(icmd_clear), .ix(ix), .iy(iy), .iw(iw), .ih(ih), .icolor(icolor),
    .ihold(ihold), .owren(owren), .odata(odata), .oaddr(oaddr), .obusy(obusy),
    .odone(odone)
  );

  typedef struct packed {
    logic [18:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  acc_cyc = 0;
  int  cur_nw = 0;
  int  wr_since_acc = 0;
  int  first_wr_cyc = 0;
  int  last_wr_cyc = 0;
  int  done_cyc = 0;
  int  done_cnt = 0;
  int  exp_done = 0;
  bit  prev_done = 0;
  bit  hold_en = 0;

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;
  always @(posedge iclk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected writes: every visible pixel of the clipped rectangle, row by row.
  task automatic model_push(input bit clr, input int x, input int y, input int w,
                            input int h, input int c, output int n);
    int xe;
    int ye;
    wr_t e;
    n = 0;
    if (clr) begin
      x = 0; y = 0; w = H; h = V;
    end
    xe = (x + w < H) ? x + w : H;
    ye = (y + h < V) ? y + h : V;
    for (int r = y; r < ye; r++) begin
      for (int col = x; col < xe; col++) begin
        e.a = 19'(r * H + col);
        e.d = 8'(c);
        exp_q.push_back(e);
        n++;
      end
    end
  endtask

  initial begin
    ihold = 1'b0;
    forever begin
      @(posedge iclk);
      #1;
      ihold = hold_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  always @(negedge iclk) begin
    if (iRST_n === 1'b1) begin
      chk(ocmd_ready == !obusy, "ready_vs_busy", ocmd_ready, !obusy);
      if (prev_done) chk(ocmd_ready === 1'b1, "ready_after_done", ocmd_ready, 1);
      prev_done = odone;
      if (owren === 1'b1) begin
        chk(ihold == 1'b0, "write_under_hold", ihold, 0);
        chk(obusy == 1'b1, "busy_during_write", obusy, 1);
        chk(oaddr < 19'd307200, "addr_range", oaddr, 307199);
        chk(exp_q.size() != 0, "write_expected", oaddr, -1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk(oaddr == mon_e.a, "write_addr", oaddr, mon_e.a);
          chk(odata == mon_e.d, "write_data", odata, mon_e.d);
        end
        if (wr_since_acc == 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        wr_since_acc++;
      end
      if (odone === 1'b1) begin
        chk(exp_q.size() == 0, "done_with_pending", exp_q.size(), 0);
        if (cur_nw > 0) chk(last_wr_cyc == cyc - 1, "done_after_last_write", last_wr_cyc, cyc - 1);
        else            chk(cyc == acc_cyc + 2, "empty_done_latency", cyc - acc_cyc, 2);
        done_cyc = cyc;
        done_cnt++;
      end
    end
  end

  task automatic issue(input bit clr, input int x, input int y, input int w,
                       input int h, input int c);
    int n = 0;
    icmd_clear = clr;
    ix = 10'(x); iy = 9'(y); iw = 10'(w); ih = 9'(h); icolor = 8'(c);
    icmd_valid = 1'b1;
    while (ocmd_ready !== 1'b1 && n < 20000) begin
      @(posedge iclk);
      #1;
      n++;
    end
    chk(ocmd_ready === 1'b1, "accept_timeout", n, 0);
    model_push(clr, int'(ix), int'(iy), int'(iw), int'(ih), int'(icolor), cur_nw);
    acc_cyc = cyc;
    wr_since_acc = 0;
    exp_done = done_cnt + 1;
    @(posedge iclk);
    #1;
    icmd_valid = 1'b0;
    icmd_clear = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt < exp_done && n < 20000) begin
      @(posedge iclk);
      #1;
      n++;
    end
    chk(done_cnt >= exp_done, "done_timeout", done_cnt, exp_done);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(owren === 1'b0,      {tag, "_owren"}, owren, 0);
    chk(odata === 8'd0,      {tag, "_odata"}, odata, 0);
    chk(oaddr === 19'd0,     {tag, "_oaddr"}, oaddr, 0);
    chk(ocmd_ready === 1'b1, {tag, "_ready"}, ocmd_ready, 1);
    chk(obusy === 1'b0,      {tag, "_busy"},  obusy, 0);
    chk(odone === 1'b0,      {tag, "_done"},  odone, 0);
  endtask

  task automatic reset_after(input int nwr, input string tag);
    int n = 0;
    while (wr_since_acc < nwr && n < 5000) begin
      @(posedge iclk);
      #1;
      n++;
    end
    chk(wr_since_acc >= nwr, {tag, "_reach_writes"}, wr_since_acc, nwr);
    #2;
    iRST_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    exp_q.delete();
    prev_done = 0;
    repeat (3) @(posedge iclk);
    #1;
    chk(owren === 1'b0, {tag, "_no_write_in_reset"}, owren, 0);
    @(negedge iclk);
    iRST_n = 1'b1;
    @(posedge iclk);
    #1;
  endtask

  initial begin
    int x, y, w, h;
    iRST_n = 1'b1;
    icmd_valid = 1'b0; icmd_clear = 1'b0;
    ix = '0; iy = '0; iw = '0; ih = '0; icolor = '0;
    #1 iRST_n = 1'b0;
    #1 check_reset_outputs("por");
    repeat (3) @(posedge iclk);
    @(negedge iclk);
    iRST_n = 1'b1;
    @(posedge iclk);
    #1;

    // basic 2x2 rectangle with exact cycle placement
    issue(0, 10, 5, 2, 2, 8'h3C);
    wait_done();
    chk(first_wr_cyc == acc_cyc + 2, "rect_first_write_lat", first_wr_cyc - acc_cyc, 2);
    chk(done_cyc == acc_cyc + 6, "rect_done_lat", done_cyc - acc_cyc, 6);
    chk(wr_since_acc == 4, "rect_write_count", wr_since_acc, 4);
    @(posedge iclk); #1;

    // clip at the bottom-right corner
    issue(0, 638, 479, 10, 4, 8'hA5);
    wait_done();
    chk(wr_since_acc == 2, "clip_write_count", wr_since_acc, 2);

    // empty rectangles
    issue(0, 50, 50, 0, 3, 8'h11);
    wait_done();
    chk(wr_since_acc == 0, "empty_w0_writes", wr_since_acc, 0);
    issue(0, 700, 10, 5, 3, 8'h22);
    wait_done();
    chk(wr_since_acc == 0, "empty_x700_writes", wr_since_acc, 0);

    // held stalls plus a command waiting while busy
    hold_en = 1;
    issue(0, 100, 50, 4, 3, 8'h77);
    issue(0, 200, 60, 4, 3, 8'h78);
    chk(acc_cyc == done_cyc + 1, "held_cmd_accept_after_done", acc_cyc, done_cyc + 1);
    wait_done();
    chk(wr_since_acc == 12, "hold_write_count", wr_since_acc, 12);

    // randomised rectangles, some near the edges, hold on for half
    for (int k = 0; k < 24; k++) begin
      hold_en = (k % 2) == 1;
      x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(600, 700)) : int'($urandom_range(0, 639));
      y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(470, 500)) : int'($urandom_range(0, 479));
      w = int'($urandom_range(0, 12));
      h = int'($urandom_range(0, 5));
      issue(0, x, y, w, h, int'($urandom_range(0, 255)));
      wait_done();
      chk(wr_since_acc == cur_nw, "rand_write_count", wr_since_acc, cur_nw);
    end
    hold_en = 0;
    @(posedge iclk); #1;

    // clear command: coordinates ignored, ascending stream from address 0
    issue(1, 123, 45, 7, 8, 8'h00);
    chk(cur_nw == H * V, "clear_model_size", cur_nw, H * V);
    reset_after(2000, "clear_abort");

    // reset mid-fill, then a fresh command from its own origin
    issue(0, 50, 20, 100, 100, 8'hC3);
    reset_after(5, "fill_abort");
    issue(0, 7, 3, 3, 2, 8'h5A);
    wait_done();
    chk(first_wr_cyc == acc_cyc + 2, "post_reset_first_write_lat", first_wr_cyc - acc_cyc, 2);
    chk(wr_since_acc == 6, "post_reset_write_count", wr_since_acc, 6);

    repeat (3) @(posedge iclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
